// File: rtl/vertical_timing_ctrl.sv
// Vertical timing stage of the VGA controller.
// Counts lines on each line-end pulse (ven) from the horizontal stage and
// derives vsync, the vertical active flag, a frame-start strobe and a frame
// counter. Every output is registered and decodes the line being entered, so
// each one changes on the same edge as vcount.
module vertical_timing_ctrl #(
   parameter int V_ACTIVE  = 480,   // visible lines
   parameter int V_FP      = 10,    // front-porch lines (0 skips the state)
   parameter int V_SYNC    = 2,     // sync-pulse lines, at least 1
   parameter int V_BP      = 33,    // back-porch lines (0 skips the state)
   parameter bit VSYNC_NEG = 1'b1,  // 1: vsync active-low
   parameter int CNT_W     = 16,
   parameter int FRAME_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ven,
   output logic [CNT_W-1:0]   vcount,
   output logic               vsync,
   output logic               v_active,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic [1:0]         vstate
);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FP     = 2'd1,
      ST_SYNC   = 2'd2,
      ST_BP     = 2'd3
   } vstate_e;

   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Line numbers at which each region begins. An empty porch makes two
   // starts coincide, so that state can never be decoded.
   localparam logic [CNT_W-1:0] L_LAST       = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] L_FP_START   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] L_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] L_BP_START   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0]   r_vcount;
   vstate_e            r_state;
   logic               r_vsync;
   logic               r_v_active;
   logic               r_frame_start;
   logic [FRAME_W-1:0] r_frame_cnt;

   logic               w_wrap;
   logic [CNT_W-1:0]   w_vcount_next;
   vstate_e            w_state_next;

   // Next line number and the region it falls in.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
      w_wrap        = 1'b0;
      w_vcount_next = '0;
      w_state_next  = ST_ACTIVE;

      w_wrap        = (r_vcount == L_LAST);
      w_vcount_next = w_wrap ? '0 : r_vcount + CNT_W'(1);

      if (w_vcount_next < L_FP_START)
         w_state_next = ST_ACTIVE;
      else if (w_vcount_next < L_SYNC_START)
         w_state_next = ST_FP;
      else if (w_vcount_next < L_BP_START)
         w_state_next = ST_SYNC;
      else
         w_state_next = ST_BP;
   end

   // Line counter, FSM and registered outputs, all advanced by one sampled ven.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state uses nonblocking assignments so every register sees pre-edge values regardless of statement order.
      if (rst) begin
         r_vcount      <= '0;
         r_state       <= ST_ACTIVE;
         r_vsync       <= VSYNC_NEG;
         r_v_active    <= 1'b1;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= '0;
      end else if (ven) begin
         r_vcount      <= w_vcount_next;
         r_state       <= w_state_next;
         r_vsync       <= (w_state_next == ST_SYNC) ^ VSYNC_NEG;
         r_v_active    <= (w_state_next == ST_ACTIVE);
         r_frame_start <= w_wrap;
         if (w_wrap)
            r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end else begin
         r_frame_start <= 1'b0;
      end
   end

   assign vcount      = r_vcount;
   assign vstate      = r_state;
   assign vsync       = r_vsync;
   assign v_active    = r_v_active;
   assign frame_start = r_frame_start;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vertical_timing_ctrl.sv
// Bench for vertical_timing_ctrl. Two instances share clk/rst/ven:
//  - m_*: default 525-line timing, active-low vsync
//  - s_*: 5-line frame with empty porches and active-high vsync, so porch
//         skipping and the 256-frame counter wrap stay short.
// A line-count model (total lines since reset) predicts every output and
// is compared on each falling edge; directed checks pin literal values.
module tb_vertical_timing_ctrl;

   // Main instance geometry
   localparam int M_VA = 480, M_FP = 10, M_SY = 2, M_BP = 33;
   localparam int M_TOT = M_VA + M_FP + M_SY + M_BP;
   // Small instance geometry
   localparam int S_VA = 4, S_FP = 0, S_SY = 1, S_BP = 0;
   localparam int S_TOT = S_VA + S_FP + S_SY + S_BP;

   logic clk;
   logic rst;
   logic ven;

   logic [15:0] m_vcount;
   logic        m_vsync, m_v_active, m_frame_start;
   logic [7:0]  m_frame_cnt;
   logic [1:0]  m_vstate;

   logic [3:0]  s_vcount;
   logic        s_vsync, s_v_active, s_frame_start;
   logic [7:0]  s_frame_cnt;
   logic [1:0]  s_vstate;

   int n_checks = 0;
   int n_errors = 0;

   vertical_timing_ctrl u_main (
      .clk(clk), .rst(rst), .ven(ven),
      .vcount(m_vcount), .vsync(m_vsync), .v_active(m_v_active),
      .frame_start(m_frame_start), .frame_cnt(m_frame_cnt), .vstate(m_vstate)
   );

   vertical_timing_ctrl #(
      .V_ACTIVE(S_VA), .V_FP(S_FP), .V_SYNC(S_SY), .V_BP(S_BP),
      .VSYNC_NEG(1'b0), .CNT_W(4), .FRAME_W(8)
   ) u_small (
      .clk(clk), .rst(rst), .ven(ven),
      .vcount(s_vcount), .vsync(s_vsync), .v_active(s_v_active),
      .frame_start(s_frame_start), .frame_cnt(s_frame_cnt), .vstate(s_vstate)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned lines;     // ven samples accepted since last reset
   bit          fs_exp;    // a sampled ven just completed a frame

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         lines  = 0;
         fs_exp = 1'b0;
      end else if (ven) begin
         lines  = lines + 1;
         fs_exp = 1'b1;  // refined per geometry in the compare process
      end else begin
         fs_exp = 1'b0;
      end
   end

   function automatic int region(input int line, input int va, input int fp, input int sy);
      if (line < va)                return 0;
      else if (line < va + fp)      return 1;
      else if (line < va + fp + sy) return 2;
      else                          return 3;
   endfunction

   // Compare process: every falling edge, both instances against the model.
   always @(negedge clk) begin
      int ml, sl, mr, sr;
      ml = int'(lines % M_TOT);
      sl = int'(lines % S_TOT);
      mr = region(ml, M_VA, M_FP, M_SY);
      sr = region(sl, S_VA, S_FP, S_SY);
      check("m_vcount",      m_vcount,      ml);
      check("m_vstate",      m_vstate,      mr);
      check("m_vsync",       m_vsync,       (mr == 2) ? 0 : 1);
      check("m_v_active",    m_v_active,    (mr == 0) ? 1 : 0);
      check("m_frame_start", m_frame_start, (fs_exp && lines != 0 && ml == 0) ? 1 : 0);
      check("m_frame_cnt",   m_frame_cnt,   (lines / M_TOT) % 256);
      check("s_vcount",      s_vcount,      sl);
      check("s_vstate",      s_vstate,      sr);
      check("s_vsync",       s_vsync,       (sr == 2) ? 1 : 0);
      check("s_v_active",    s_v_active,    (sr == 0) ? 1 : 0);
      check("s_frame_start", s_frame_start, (fs_exp && lines != 0 && sl == 0) ? 1 : 0);
      check("s_frame_cnt",   s_frame_cnt,   (lines / S_TOT) % 256);
   end

   // ---------------- stimulus helpers ----------------
   // All helpers start and end 1 time unit after a rising edge.
   task automatic step(input logic v);
      ven = v;
      @(posedge clk);
      #1;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1);
         step(1'b0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ven = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int fs_cycles[$];
      int low_cnt;
      logic [15:0] held_vcount;

      rst = 1'b1;
      ven = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset state
      check("rst_vcount",   m_vcount, 0);
      check("rst_vsync",    m_vsync, 1);
      check("rst_v_active", m_v_active, 1);
      check("rst_vstate",   m_vstate, 0);
      check("rst_fs",       m_frame_start, 0);
      check("rst_fcnt",     m_frame_cnt, 0);

      // Active / front-porch boundary
      pulses(480);
      check("b480_vcount",   m_vcount, 480);
      check("b480_v_active", m_v_active, 0);
      check("b480_vstate",   m_vstate, 1);
      check("b480_vsync",    m_vsync, 1);

      // Sync window
      pulses(10);
      check("b490_vsync",  m_vsync, 0);
      check("b490_vstate", m_vstate, 2);
      pulses(1);
      check("b491_vsync",  m_vsync, 0);
      pulses(1);
      check("b492_vsync",  m_vsync, 1);
      check("b492_vstate", m_vstate, 3);

      // Wrap
      pulses(32);
      check("b524_vcount", m_vcount, 524);
      step(1'b1);
      check("wrap_vcount",   m_vcount, 0);
      check("wrap_vstate",   m_vstate, 0);
      check("wrap_v_active", m_v_active, 1);
      check("wrap_fs",       m_frame_start, 1);
      check("wrap_fcnt",     m_frame_cnt, 1);
      step(1'b0);
      check("wrap_fs_drop",  m_frame_start, 0);

      // Held ven advances one line per cycle, then idle holds everything
      pulses(10);
      step(1'b1);
      step(1'b1);
      step(1'b1);
      step(1'b0);
      check("held_vcount", m_vcount, 13);
      held_vcount = m_vcount;
      for (int i = 0; i < 50; i++) step(1'b0);
      check("idle_vcount", m_vcount, 13);
      check("idle_fcnt",   m_frame_cnt, 1);

      // Asynchronous reset mid-frame at line 300
      pulses(287);
      check("pre_rst_vcount", m_vcount, 300);
      #2;
      rst = 1'b1;
      #1;
      check("arst_vcount",   m_vcount, 0);
      check("arst_vsync",    m_vsync, 1);
      check("arst_v_active", m_v_active, 1);
      check("arst_vstate",   m_vstate, 0);
      check("arst_fs",       m_frame_start, 0);
      check("arst_fcnt",     m_frame_cnt, 0);
      ven = 1'b1;  // must be ignored while in reset
      @(posedge clk);
      #1;
      check("arst_ven_ignored", m_vcount, 0);
      ven = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Integration: one line-end pulse every 20 clocks
      do_reset();
      low_cnt = 0;
      for (int c = 0; c < 2 * M_TOT * 20 + 40; c++) begin
         ven = (c % 20 == 19);
         @(posedge clk);
         #1;
         if (m_frame_start) fs_cycles.push_back(c);
         if (!m_vsync) low_cnt++;
      end
      ven = 1'b0;
      check("int_frames", fs_cycles.size(), 2);
      check("int_period", (fs_cycles.size() >= 2) ? fs_cycles[1] - fs_cycles[0] : 0, M_TOT * 20);
      check("int_vsync_low", low_cnt, 2 * M_SY * 20);

      // Small instance: empty porches and 256-frame wrap
      do_reset();
      pulses(4);
      check("s_skip_fp", s_vstate, 2);
      check("s_sync_hi", s_vsync, 1);
      pulses(1);
      check("s_skip_bp", s_vstate, 0);
      check("s_fcnt1",   s_frame_cnt, 1);
      pulses(256 * S_TOT - 6);
      check("s_fcnt255", s_frame_cnt, 255);
      check("s_line4",   s_vcount, 4);
      step(1'b1);
      check("s_fcnt_wrap", s_frame_cnt, 0);
      check("s_fs_wrap",   s_frame_start, 1);
      check("s_vcount0",   s_vcount, 0);
      step(1'b0);

      // Randomized ven with one asynchronous reset dropped in
      for (int c = 0; c < 4000; c++) begin
         if (c == 2100) begin
            #($urandom_range(1, 3));
            rst = 1'b1;
            ven = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
         end
         if ($urandom_range(0, 7) == 0)
            step(1'b0);
         else
            step(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
      end
      ven = 1'b0;
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
